// File: rtl/id_imm_if.sv
// Handshake bundle between the IF/ID register, the decode-stage immediate unit and ID/EX.
// The stage itself is the slave; the surrounding pipeline (or a bench) is the master.
interface id_imm_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, instr, pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, instr, pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
    );
endinterface

// File: rtl/id_imm_stage.sv
// Decode-stage immediate unit: classifies instruction format, builds the extended
// immediate and registers it into a single valid/ready slot with stall/flush control.
module id_imm_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    id_imm_if.slave          bus,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    function automatic dec_t decode_f(input logic [XLEN-1:0] i);
        dec_t d;
        d.imm     = 32'd0;
        d.fmt     = FMT_R;
        d.illegal = 1'b0;
        case (i[6:0])
            7'b0010011: begin
                d.fmt = FMT_I;
                // Shift-immediates carry an unsigned shamt, not a sign-extended value
                if ((i[14:12] == 3'b001) || (i[14:12] == 3'b101)) begin
                    d.imm = {27'd0, i[24:20]};
                end else begin
                    d.imm = {{20{i[31]}}, i[31:20]};
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                d.fmt = FMT_I;
                d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'b0100011: begin
                d.fmt = FMT_S;
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'b1100011: begin
                d.fmt = FMT_B;
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                d.fmt = FMT_U;
                d.imm = {i[31:12], 12'd0};
            end
            7'b1101111: begin
                d.fmt = FMT_J;
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b0110011: begin
                d.fmt = FMT_R;
                d.imm = 32'd0;
            end
            default: begin
                d.fmt     = FMT_ILL;
                d.imm     = 32'd0;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic              valid_r;
    logic [XLEN-1:0]   imm_r;
    logic [2:0]        fmt_r;
    logic [XLEN-1:0]   pc_r;
    logic              illegal_r;
    logic [CNT_W-1:0]  cnt_r;

    dec_t dec_s;
    logic in_ready_s;
    logic accept_s;
    logic drain_s;

    // Decode the incoming word and derive the handshake conditions for this cycle
    always_comb begin
        dec_s      = decode_f(bus.instr);
        in_ready_s = ~stall & ~flush & (~valid_r | bus.out_ready);
        accept_s   = bus.in_valid & in_ready_s;
        drain_s    = valid_r & bus.out_ready;
    end

    // Slot register and saturating illegal counter; reset > flush > stall > accept/drain
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r   <= 1'b0;
            imm_r     <= 32'd0;
            fmt_r     <= 3'd0;
            pc_r      <= 32'd0;
            illegal_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (stall) begin
            valid_r <= valid_r;
        end else if (accept_s) begin
            valid_r   <= 1'b1;
            imm_r     <= dec_s.imm;
            fmt_r     <= dec_s.fmt;
            pc_r      <= bus.pc;
            illegal_r <= dec_s.illegal;
            if (dec_s.illegal && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else if (drain_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = valid_r & ~stall;
    assign bus.out_imm     = imm_r;
    assign bus.out_fmt     = fmt_r;
    assign bus.out_pc      = pc_r;
    assign bus.out_illegal = illegal_r;
    assign illegal_cnt     = cnt_r;

endmodule

// File: tb/tb_id_imm_stage.sv
// Self-checking bench for id_imm_stage: directed vector table, hand-written handshake
// sequences and randomized traffic against a slot-level reference model.
module tb_id_imm_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic flush;
    logic [CNT_W-1:0] illegal_cnt;

    id_imm_if bus ();

    id_imm_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .stall       (stall),
        .flush       (flush),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference slot state
    logic        m_valid;
    logic [31:0] m_imm;
    logic [2:0]  m_fmt;
    logic [31:0] m_pc;
    logic        m_ill;
    int          m_cnt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    vec_t vecs [0:11];
    logic [6:0] opcs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediate built from the field rules with shifts and masks
    task automatic ref_dec(input logic [31:0] w, output logic [31:0] imm,
                           output logic [2:0] fmt, output logic ill);
        logic signed [31:0] s;
        logic [31:0] hi, t;
        s   = signed'(w);
        hi  = s >>> 31;
        imm = 32'd0;
        fmt = 3'd0;
        ill = 1'b0;
        case (w & 32'h7F)
            32'h13: begin
                fmt = 3'd1;
                if (((w >> 12) & 32'h7) == 32'd1 || ((w >> 12) & 32'h7) == 32'd5)
                    imm = (w >> 20) & 32'h1F;
                else begin
                    t = s >>> 20;
                    imm = t;
                end
            end
            32'h03, 32'h67, 32'h73: begin
                fmt = 3'd1;
                t = s >>> 20;
                imm = t;
            end
            32'h23: begin
                fmt = 3'd2;
                t = s >>> 25;
                imm = (t << 5) | ((w >> 7) & 32'h1F);
            end
            32'h63: begin
                fmt = 3'd3;
                imm = (hi << 12) | (((w >> 7) & 32'd1) << 11)
                    | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
            end
            32'h37, 32'h17: begin
                fmt = 3'd4;
                imm = w & 32'hFFFFF000;
            end
            32'h6F: begin
                fmt = 3'd5;
                imm = (hi << 20) | (w & 32'h000FF000)
                    | (((w >> 20) & 32'd1) << 11) | (((w >> 21) & 32'h3FF) << 1);
            end
            32'h33: fmt = 3'd0;
            default: begin
                fmt = 3'd7;
                ill = 1'b1;
            end
        endcase
    endtask

    task automatic check_model();
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid & ~stall});
        chk("in_ready", {31'd0, bus.in_ready},
            {31'd0, ~stall & ~flush & (~m_valid | bus.out_ready)});
        chk("out_imm", bus.out_imm, m_imm);
        chk("out_fmt", {29'd0, bus.out_fmt}, {29'd0, m_fmt});
        chk("out_pc", bus.out_pc, m_pc);
        chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, m_ill});
        chk("illegal_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'(m_cnt));
    endtask

    // One clock: predict next slot from the inputs, take the edge, compare
    task automatic tick();
        logic acc;
        logic [31:0] di, ipc;
        logic [2:0] df;
        logic dl;
        acc = bus.in_valid && !stall && !flush && (!m_valid || bus.out_ready);
        ref_dec(bus.instr, di, df, dl);
        ipc = bus.pc;
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_imm = 32'd0; m_fmt = 3'd0; m_pc = 32'd0; m_ill = 1'b0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (stall) begin
            m_valid = m_valid;
        end else if (acc) begin
            m_valid = 1'b1; m_imm = di; m_fmt = df; m_pc = ipc; m_ill = dl;
            if (dl && m_cnt < CNT_TOP) m_cnt++;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] r;
        int saved_cnt;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2};
        vecs[2]  = '{32'h4051D093, 32'h00000005, 3'd1};
        vecs[3]  = '{32'h80000063, 32'hFFFFF000, 3'd3};
        vecs[4]  = '{32'h800000EF, 32'hFFF00000, 3'd5};
        vecs[5]  = '{32'h123450B7, 32'h12345000, 3'd4};
        vecs[6]  = '{32'h00000033, 32'h00000000, 3'd0};
        vecs[7]  = '{32'h0000007F, 32'h00000000, 3'd7};
        vecs[8]  = '{32'h00A12083, 32'h0000000A, 3'd1};
        vecs[9]  = '{32'h7FF00067, 32'h000007FF, 3'd1};
        vecs[10] = '{32'hFFFFF017, 32'hFFFFF000, 3'd4};
        vecs[11] = '{32'h01F09093, 32'h0000001F, 3'd1};
        opcs = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        m_valid = 1'b0; m_imm = 32'd0; m_fmt = 3'd0; m_pc = 32'd0; m_ill = 1'b0; m_cnt = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.instr = 32'd0; bus.pc = 32'd0; bus.out_ready = 1'b1;
        #2;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Directed decode table, back-to-back with a free consumer
        for (int k = 0; k < 12; k++) begin
            bus.in_valid = 1'b1; bus.instr = vecs[k].instr; bus.pc = 32'h1000 + 32'(4 * k);
            bus.out_ready = 1'b1;
            tick();
            chk("vec_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("vec_imm", bus.out_imm, vecs[k].imm);
            chk("vec_fmt", {29'd0, bus.out_fmt}, {29'd0, vecs[k].fmt});
        end

        // Backpressure: slot held while consumer is busy, then drain+accept together
        bus.instr = 32'hFFF00093; tick();
        bus.instr = 32'h80000063; bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_imm_stable", bus.out_imm, 32'hFFFFFFFF);
        end
        bus.instr = 32'h123450B7; bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("bp_new_imm", bus.out_imm, 32'h12345000);

        // Stall freezes the slot; flush kills slot and input
        stall = 1'b1; bus.instr = 32'h800000EF;
        #1;
        chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        tick();
        stall = 1'b0;
        #1;
        chk("unstall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("unstall_imm", bus.out_imm, 32'h12345000);
        saved_cnt = m_cnt;
        flush = 1'b1; bus.instr = 32'h0000007F;
        tick();
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'(saved_cnt));
        flush = 1'b0; bus.in_valid = 1'b0;
        tick();

        // Counter saturation and reset during a valid slot
        reset = 1'b1; tick(); reset = 1'b0;
        bus.in_valid = 1'b1; bus.instr = 32'h0000007F; bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("cnt_saturated", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'd15);
        bus.in_valid = 1'b0; reset = 1'b1;
        tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'd0);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            r = $urandom();
            bus.in_valid  = ($urandom_range(0, 99) < 75);
            bus.out_ready = ($urandom_range(0, 99) < 65);
            stall         = ($urandom_range(0, 99) < 10);
            flush         = ($urandom_range(0, 99) < 6);
            reset         = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) bus.instr = r;
            else bus.instr = {r[31:7], opcs[$urandom_range(0, 10)]};
            bus.pc = $urandom();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
